prescaled_mod_counter: RTL and testbench

//   Parametrised successor to the 4-bit ripple counter on the board top level.

---
 rtl/prescaled_mod_counter.sv | 54 +++++
 tb/tb_prescaled_mod_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prescaled_mod_counter.sv
// prescaled_mod_counter: prescaled modulo-N up/down counter with load, enable and terminal-count pulse.
// Define COUNT_GRAY_OUT_EN to drive count as Gray code of the internal binary value.
module prescaled_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [PS_W-1:0] PS_TOP = PS_W'(PRESCALE - 1);
    logic [WIDTH-1:0] bin, bin_nx, count_nx;
    logic [PS_W-1:0] ps_cnt;
    logic step, wrap;
    always_comb begin
        step = en && ps_cnt == PS_TOP;
        wrap = up ? bin == TOP : bin == '0;
        bin_nx = load  ? ({1'b0, load_val} >= MOD_EXT ? TOP : load_val) :
                 !step ? bin :
                 wrap  ? (up ? '0 : TOP) :
                 up    ? bin + 1'b1 : bin - 1'b1;
`ifdef COUNT_GRAY_OUT_EN
        count_nx = bin_nx ^ (bin_nx >> 1);
`else
        count_nx = bin_nx;
`endif
    end
    // count is re-registered from bin_nx so it never lags the tick/tc pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            bin    <= '0;
            count  <= '0;
            ps_cnt <= '0;
            tick   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            bin    <= bin_nx;
            count  <= count_nx;
            ps_cnt <= (load || step) ? '0 : en ? ps_cnt + 1'b1 : ps_cnt;
            tick   <= step && !load;
            tc     <= step && !load && wrap;
        end
    end
endmodule

// File: tb/tb_prescaled_mod_counter.sv
// tb_prescaled_mod_counter: scoreboard bench for WIDTH=4, MODULO=10, PRESCALE=3 in the binary build.
module tb_prescaled_mod_counter;
    typedef struct packed {
        logic [3:0] c;
        logic       t;
        logic       tc;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic tick, tc;
    exp_t sb[$];
    int m_c = 0, m_ps = 0;
    int vecs = 0, fails = 0;
    prescaled_mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .tc(tc)
    );
    always #5 clk = ~clk;
    // drive one cycle of stimulus, push the reference result, wait past the edge
    task automatic apply(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_val = v;
        x.t = 1'b0;
        x.tc = 1'b0;
        if (r) begin
            m_c = 0;
            m_ps = 0;
        end else if (l) begin
            m_c = v >= 4'd10 ? 9 : int'(v);
            m_ps = 0;
        end else if (e) begin
            if (m_ps == 2) begin
                m_ps = 0;
                x.t = 1'b1;
                x.tc = u ? m_c == 9 : m_c == 0;
                m_c = u ? (m_c + 1) % 10 : (m_c + 9) % 10;
            end else m_ps++;
        end
        x.c = 4'(m_c);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        exp_t x;
        for (int i = 0; i < 5; i++) begin
            apply(i < 2, 1'b1, 1'b1, 1'b0, 4'd0);
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_reset cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
        end
        vecs++;
        if (count !== 4'd1 || tick !== 1'b1) begin
            fails++;
            $display("FAIL test_reset first_tick: count=%0d tick=%b, want count=1 tick=1", count, tick);
        end
    endtask
    task automatic test_up_wrap;
        exp_t x;
        int ticks = 0, tcs = 0;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 30; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_up_wrap cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
            if (tick === 1'b1) ticks++;
            if (tc === 1'b1) begin
                tcs++;
                vecs++;
                if (count !== 4'd0) begin
                    fails++;
                    $display("FAIL test_up_wrap tc_pos: count=%0d with tc, want 0", count);
                end
            end
        end
        vecs++;
        if (ticks != 10 || tcs != 1) begin
            fails++;
            $display("FAIL test_up_wrap pulses: ticks=%0d tcs=%0d, want 10 and 1", ticks, tcs);
        end
    endtask
    task automatic test_down;
        exp_t x;
        apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_down cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
            if (i == 2) begin
                vecs++;
                if (count !== 4'd9 || tc !== 1'b1) begin
                    fails++;
                    $display("FAIL test_down wrap: count=%0d tc=%b, want 9 and 1", count, tc);
                end
            end
        end
        vecs++;
        if (count !== 4'd8 || tc !== 1'b0 || tick !== 1'b1) begin
            fails++;
            $display("FAIL test_down second: count=%0d tick=%b tc=%b, want 8 1 0", count, tick, tc);
        end
    endtask
    task automatic test_hold;
        exp_t x;
        logic e;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            e = i == 0 || i >= 6;
            apply(1'b0, e, 1'b1, 1'b0, 4'd0);
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_hold cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
        end
        vecs++;
        if (count !== 4'd5 || tick !== 1'b1) begin
            fails++;
            $display("FAIL test_hold resume: count=%0d tick=%b, want 5 and 1", count, tick);
        end
    endtask
    task automatic test_load;
        exp_t x;
        logic [3:0] lv;
        logic l;
        apply(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            l = i == 2 || i == 3;
            lv = i == 2 ? 4'd7 : 4'd12;
            apply(1'b0, 1'b1, 1'b1, l, lv);
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_load cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
            if (i == 2) begin
                vecs++;
                if (count !== 4'd7 || tick !== 1'b0) begin
                    fails++;
                    $display("FAIL test_load over_step: count=%0d tick=%b, want 7 and 0", count, tick);
                end
            end
            if (i == 3) begin
                vecs++;
                if (count !== 4'd9) begin
                    fails++;
                    $display("FAIL test_load clamp: count=%0d, want 9", count);
                end
            end
        end
        vecs++;
        if (count !== 4'd0 || tick !== 1'b1 || tc !== 1'b1) begin
            fails++;
            $display("FAIL test_load after: count=%0d tick=%b tc=%b, want 0 1 1", count, tick, tc);
        end
    endtask
    task automatic test_random;
        exp_t x;
        for (int i = 0; i < 300; i++) begin
            apply($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 15) == 0, 4'($urandom));
            x = sb.pop_front();
            vecs++;
            if ({count, tick, tc} !== {x.c, x.t, x.tc}) begin
                fails++;
                $display("FAIL test_random cyc %0d: count=%0d tick=%b tc=%b, want count=%0d tick=%b tc=%b", i, count, tick, tc, x.c, x.t, x.tc);
            end
        end
    endtask
    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_hold();
        test_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
